// File: rtl/fric_resp_xactor.sv
// Register-file responder for the FRIC master_* handshake: stores writes, returns reads after RD_LATENCY cycles.
// Optional pseudo-random back-pressure is enabled by defining FRIC_RESP_STALL_EN.
module fric_resp_xactor #(
    parameter int RD_LATENCY = 2,
    parameter int PORT_BITS  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  master_type,
    input  logic [3:0]  master_port,
    input  logic [7:0]  master_addr,
    input  logic [15:0] master_wdat,
    input  logic        master_tstb,
    output logic        master_trdy,
    output logic        master_rstb,
    output logic [15:0] master_rdat,
    output logic        resp_err
);

    // state    | meaning
    // ST_IDLE  | ready for a transaction (unless stalled or just out of reset)
    // ST_RWAIT | read accepted, counting down the remaining latency
    // ST_RDATA | read data presented on master_rdat with master_rstb high
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RWAIT = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;

    localparam logic [3:0] TYPE_WR = 4'h0;
    localparam logic [3:0] TYPE_RD = 4'h1;

    localparam int         IDX_W  = PORT_BITS + 8;
    localparam int         DEPTH  = 1 << IDX_W;
    localparam logic [3:0] LAT_M1 = 4'(RD_LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [15:0]      hold_q;
    logic [15:0]      rdat_q;
    logic             err_q;
    logic [1:0]       rdy_pipe_q;
    logic             stall;
    logic             accept;
    logic             is_wr;
    logic             is_rd;
    logic             is_bad;
    logic [IDX_W-1:0] idx;
    logic [15:0]      rd_word;
    logic             unused_port;

    logic [15:0] mem [DEPTH];

    generate
        if (PORT_BITS == 0) begin : g_idx_addr
            assign idx = master_addr;
        end else begin : g_idx_port
            assign idx = {master_port[PORT_BITS-1:0], master_addr};
        end
    endgenerate

    assign unused_port = ^master_port;
    assign rd_word     = mem[idx];

`ifdef FRIC_RESP_STALL_EN
    logic [7:0] lfsr_q;

    // Fibonacci LFSR, taps 8,6,5,4
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // rdy_pipe_q keeps trdy low for one full cycle after the first non-reset edge
    assign master_trdy = (state_q == ST_IDLE) && rdy_pipe_q[1] && !stall;
    assign accept      = master_tstb && master_trdy;
    assign is_wr       = accept && (master_type == TYPE_WR);
    assign is_rd       = accept && (master_type == TYPE_RD);
    assign is_bad      = accept && (master_type != TYPE_WR) && (master_type != TYPE_RD);

    assign master_rstb = (state_q == ST_RDATA);
    assign master_rdat = rdat_q;
    assign resp_err    = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (is_rd) begin
                    if (RD_LATENCY == 1) begin
                        state_d = ST_RDATA;
                    end else begin
                        state_d = ST_RWAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            ST_RWAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            hold_q     <= 16'h0000;
            rdat_q     <= 16'h0000;
            err_q      <= 1'b0;
            rdy_pipe_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= is_bad;
            rdy_pipe_q <= {rdy_pipe_q[0], 1'b1};
            if (is_rd) begin
                hold_q <= rd_word;
            end
            // With a one-cycle latency the holding register is bypassed
            if (state_d == ST_RDATA && state_q != ST_RDATA) begin
                rdat_q <= (state_q == ST_IDLE) ? rd_word : hold_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (is_wr && !rst) begin
            mem[idx] <= master_wdat;
        end
    end

endmodule
